input_periph_bank: RTL and testbench

- Parametrised input-peripheral front end for the hart's input_peripherals_mem region. It replaces the per-bit switch and key flops of the demo top level.
- Each of NUM_CH raw board inputs passes through:
  - optional polarity inversion,
  - a 2-flop synchroniser,
  - a per-channel debounce counter,
  - rise/fall edge detection with sticky, write-1-to-clear event flags.
- Presents one status byte per channel for direct mapping into input_peripherals_mem, plus a level-sensitive irq.

---
 rtl/input_periph_bank.sv | 83 ++++++++
 tb/tb_input_periph_bank.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/input_periph_bank.sv
// input_periph_bank: invert, synchronise, debounce and edge-flag NUM_CH board inputs as memory-mapped status bytes.
// Define INPUT_PERIPH_PRESS_COUNT_EN to add a 5-bit per-channel rise counter in status bits 7:3.
module input_periph_bank #(
    parameter int                NUM_CH          = 14,
    parameter int                DEBOUNCE_CYCLES = 500000,
    parameter logic [NUM_CH-1:0] INVERT_MASK     = 14'b11110000000000,
    parameter logic [NUM_CH-1:0] IRQ_MASK        = '1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_CH-1:0]      i_raw_in,
    input  logic                   i_clr_valid,
    input  logic [7:0]             i_clr_ch,
    input  logic [1:0]             i_clr_mask,
    output logic [NUM_CH-1:0]      o_level_out,
    output logic [NUM_CH-1:0][7:0] o_status_bytes,
    output logic                   o_irq
);
    localparam int            CW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CH-1:0] r_s1, r_s2;
    logic [NUM_CH-1:0] w_rise;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_raw_in ^ INVERT_MASK;
            r_s2 <= r_s1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CW-1:0] r_cnt;
        logic          r_stable, r_rise, r_fall;
        logic          w_commit, w_rise_p, w_fall_p, w_clr_rise, w_clr_fall;
        logic [4:0]    w_hi;

        assign w_commit   = (r_s2[i] != r_stable) && (r_cnt == LAST);
        assign w_rise_p   = w_commit & r_s2[i];
        assign w_fall_p   = w_commit & ~r_s2[i];
        assign w_clr_rise = i_clr_valid && (i_clr_ch == 8'(i)) && i_clr_mask[0];
        assign w_clr_fall = i_clr_valid && (i_clr_ch == 8'(i)) && i_clr_mask[1];

        // Any sample matching the accepted level restarts the full window.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
                r_rise   <= 1'b0;
                r_fall   <= 1'b0;
            end else begin
                r_cnt    <= (r_s2[i] == r_stable || w_commit) ? '0 : r_cnt + 1'b1;
                r_stable <= w_commit ? r_s2[i] : r_stable;
                r_rise   <= w_rise_p | (r_rise & ~w_clr_rise);
                r_fall   <= w_fall_p | (r_fall & ~w_clr_fall);
            end
        end

`ifdef INPUT_PERIPH_PRESS_COUNT_EN
        logic [4:0] r_presses;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)
                r_presses <= '0;
            else if (w_rise_p)
                r_presses <= w_clr_rise ? 5'd1 : r_presses + 5'd1;
            else if (w_clr_rise)
                r_presses <= '0;
        end
        assign w_hi = r_presses;
`else
        assign w_hi = '0;
`endif

        assign w_rise[i]         = r_rise;
        assign o_level_out[i]    = r_stable;
        assign o_status_bytes[i] = {w_hi, r_fall, r_rise, r_stable};
    end

    assign o_irq = |(w_rise & IRQ_MASK);
endmodule

// File: tb/tb_input_periph_bank.sv
// tb_input_periph_bank: directed table plus randomized traffic checked against a window-based debounce model.
module tb_input_periph_bank;
    localparam int            N    = 14;
    localparam int            D    = 4;
    localparam logic [N-1:0]  INV  = 14'h3C00;
    localparam logic [N-1:0]  IRQM = '1;
`ifdef INPUT_PERIPH_PRESS_COUNT_EN
    localparam logic [7:0]    SBM  = 8'h07;
`else
    localparam logic [7:0]    SBM  = 8'hFF;
`endif

    logic             clk = 0;
    logic             rst_n = 0;
    logic [N-1:0]     raw = INV;
    logic             cv = 0;
    logic [7:0]       cc = 0;
    logic [1:0]       cm = 0;
    logic [N-1:0]     level;
    logic [N-1:0][7:0] sb;
    logic             irq;

    int checks = 0;
    int errors = 0;

    input_periph_bank #(.NUM_CH(N), .DEBOUNCE_CYCLES(D), .INVERT_MASK(INV), .IRQ_MASK(IRQM)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_raw_in(raw), .i_clr_valid(cv), .i_clr_ch(cc),
        .i_clr_mask(cm), .o_level_out(level), .o_status_bytes(sb), .o_irq(irq)
    );

    always #5 clk = ~clk;

    // Reference: a channel accepts a new level once its last D synchronised samples all disagree with it.
    logic [N-1:0] m_p1, m_p2, m_stable, m_rise, m_fall;
    logic [N-1:0] m_hist[$];
    int           m_press[N];

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
        m_hist.delete();
        for (int c = 0; c < N; c++) m_press[c] = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] smp;
        if (!rst_n) begin
            model_reset();
            return;
        end
        smp = m_p2; m_p2 = m_p1; m_p1 = raw ^ INV;
        m_hist.push_back(smp);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        for (int c = 0; c < N; c++) begin
            bit all_diff, rp, fp, cr, cf;
            all_diff = (m_hist.size() == D);
            foreach (m_hist[k]) if (m_hist[k][c] == m_stable[c]) all_diff = 0;
            rp = all_diff && !m_stable[c];
            fp = all_diff && m_stable[c];
            if (all_diff) m_stable[c] = ~m_stable[c];
            cr = cv && cc == c && cm[0];
            cf = cv && cc == c && cm[1];
            m_rise[c] = rp || (m_rise[c] && !cr);
            m_fall[c] = fp || (m_fall[c] && !cf);
`ifdef INPUT_PERIPH_PRESS_COUNT_EN
            if (rp) m_press[c] = cr ? 1 : (m_press[c] + 1) % 32;
            else if (cr) m_press[c] = 0;
`endif
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        logic [N-1:0][7:0] e;
        for (int c = 0; c < N; c++) e[c] = {5'(m_press[c]), m_fall[c], m_rise[c], m_stable[c]};
        check("model_level", 128'(level), 128'(m_stable));
        check("model_status", 128'(sb), 128'(e));
        check("model_irq", 128'(irq), 128'(|(m_rise & IRQM)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        compare_model();
    endtask

    typedef struct {
        logic [N-1:0] raw;
        logic         cv;
        logic [7:0]   cc;
        logic [1:0]   cm;
        int           n;
        int           ch;
        logic [7:0]   sb;
        logic         irq;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{14'h3C00, 0, 8'd0,  2'b00, 4, 10, 8'h00, 0};
        tbl[1]  = '{14'h3800, 0, 8'd0,  2'b00, 5, 10, 8'h00, 0};
        tbl[2]  = '{14'h3800, 0, 8'd0,  2'b00, 1, 10, 8'h03, 1};
        tbl[3]  = '{14'h3801, 0, 8'd0,  2'b00, 3, 0,  8'h00, 1};
        tbl[4]  = '{14'h3800, 0, 8'd0,  2'b00, 1, 0,  8'h00, 1};
        tbl[5]  = '{14'h3801, 0, 8'd0,  2'b00, 5, 0,  8'h00, 1};
        tbl[6]  = '{14'h3801, 0, 8'd0,  2'b00, 1, 0,  8'h03, 1};
        tbl[7]  = '{14'h3801, 1, 8'd0,  2'b01, 1, 0,  8'h01, 1};
        tbl[8]  = '{14'h3801, 1, 8'd10, 2'b01, 1, 10, 8'h01, 0};
        tbl[9]  = '{14'h3801, 1, 8'd20, 2'b11, 1, 10, 8'h01, 0};
        tbl[10] = '{14'h3C01, 0, 8'd0,  2'b00, 6, 10, 8'h04, 0};
        tbl[11] = '{14'h3C01, 1, 8'd10, 2'b00, 1, 10, 8'h04, 0};
        tbl[12] = '{14'h3C01, 1, 8'd10, 2'b10, 1, 10, 8'h00, 0};
        tbl[13] = '{14'h3401, 0, 8'd0,  2'b00, 5, 11, 8'h00, 0};
        tbl[14] = '{14'h3401, 1, 8'd11, 2'b01, 1, 11, 8'h03, 1};
        tbl[15] = '{14'h3401, 1, 8'd11, 2'b01, 1, 11, 8'h01, 0};

        model_reset();
        #1;
        check("reset_level", 128'(level), 128'(0));
        check("reset_status", 128'(sb), 128'(0));
        check("reset_irq", 128'(irq), 128'(0));
        repeat (3) step();
        rst_n = 1;

        foreach (tbl[t]) begin
            raw = tbl[t].raw; cv = tbl[t].cv; cc = tbl[t].cc; cm = tbl[t].cm;
            for (int k = 0; k < tbl[t].n; k++) begin
                step();
                cv = 0;
            end
            check($sformatf("tbl%0d_status", t), 128'(sb[tbl[t].ch] & SBM), 128'(tbl[t].sb));
            check($sformatf("tbl%0d_irq", t), 128'(irq), 128'(tbl[t].irq));
        end

        // Reset during a debounce window discards the partial count.
        raw = 14'h2401;
        repeat (3) step();
        rst_n = 0;
        #1;
        check("midrst_level", 128'(level), 128'(0));
        check("midrst_status", 128'(sb), 128'(0));
        check("midrst_irq", 128'(irq), 128'(0));
        repeat (2) step();
        rst_n = 1;
        repeat (5) step();
        check("postrst_level_early", 128'(level), 128'(0));
        step();
        check("postrst_level", 128'(level), 128'(14'h1801));

`ifdef INPUT_PERIPH_PRESS_COUNT_EN
        for (int p = 0; p < 33; p++) begin
            raw[13] = 1'b0;
            repeat (D + 2) step();
            raw[13] = 1'b1;
            repeat (D + 2) step();
        end
        check("press_wrap", 128'(sb[13][7:3]), 128'(1));
        cv = 1; cc = 8'd13; cm = 2'b01;
        step();
        cv = 0;
        check("press_clear", 128'(sb[13][7:3]), 128'(0));
`endif

        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 3) == 0) raw[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                cv = 1; cc = 8'($urandom_range(0, 15)); cm = 2'($urandom_range(0, 3));
            end
            step();
            cv = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
